// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for alu_arbiter: slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int W   = 16,
  parameter int OPW = 3
);
  logic           req0_valid;
  logic           req0_ready;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic [OPW-1:0] req0_op;

  logic           req1_valid;
  logic           req1_ready;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic [OPW-1:0] req1_op;

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_r;
  logic           alu_zero;
  logic           alu_ovfl;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_r;
  logic           rsp_zero;
  logic           rsp_ovfl;
  logic           rsp_err;

  logic           ovfl_trap;
  logic           trap_clr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_r, alu_zero, alu_ovfl,
    output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_ovfl, rsp_err,
    input  rsp_ready,
    output ovfl_trap,
    input  trap_clr
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_r, alu_zero, alu_ovfl,
    input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_ovfl, rsp_err,
    output rsp_ready,
    input  ovfl_trap,
    output trap_clr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU16b between two requesters; accept -> rsp_valid two cycles later, response held until rsp_ready.
// Optional sticky overflow trap enabled by defining ALU_ARB_OVFL_TRAP_EN (otherwise ovfl_trap is tied low).
module alu_arbiter #(
  parameter int W      = 16,
  parameter int OPW    = 3,
  parameter int MAX_OP = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OPW-1:0] OP_MAX = OPW'(MAX_OP);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);

  logic [1:0]     state_q, state_d;
  logic           last_grant_q;
  logic [W-1:0]   a_q, b_q;
  logic [OPW-1:0] op_q;
  logic           id_q;
  logic           rsp_valid_q;
  logic [W-1:0]   rsp_r_q;
  logic           rsp_zero_q, rsp_ovfl_q, rsp_err_q;

  logic gnt0, gnt1, accept;
  logic op_legal, res_ovfl;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign accept   = gnt0 | gnt1;
  assign op_legal = (op_q <= OP_MAX);
  assign res_ovfl = bus.alu_ovfl && ((op_q == OP_ADD) || (op_q == OP_SUB));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_r_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovfl_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= gnt1 ? bus.req1_a  : bus.req0_a;
        b_q          <= gnt1 ? bus.req1_b  : bus.req0_b;
        op_q         <= gnt1 ? bus.req1_op : bus.req0_op;
        id_q         <= gnt1;
        last_grant_q <= gnt1;
      end
      // Illegal ops still consume the EXEC slot but the ALU result is discarded.
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_r_q     <= op_legal ? bus.alu_r : '0;
        rsp_zero_q  <= op_legal && bus.alu_zero;
        rsp_ovfl_q  <= op_legal && res_ovfl;
        rsp_err_q   <= !op_legal;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_r      = rsp_r_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_ovfl   = rsp_ovfl_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_ARB_OVFL_TRAP_EN
  logic trap_q;

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (state_q == EXEC && op_legal && res_ovfl) begin
      trap_q <= 1'b1;
    end else if (bus.trap_clr) begin
      trap_q <= 1'b0;
    end
  end

  assign bus.ovfl_trap = trap_q;
`else
  logic trap_clr_unused;
  assign trap_clr_unused = bus.trap_clr;
  assign bus.ovfl_trap   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU16b attached to the alu_* port.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef ALU_ARB_OVFL_TRAP_EN
  localparam logic TRAP_EXP = 1'b1;
`else
  localparam logic TRAP_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ALU16b reference behaviour
  always_comb begin
    logic [15:0] r;
    logic        v;
    r = 16'h0000;
    v = 1'b0;
    case (bus.alu_op)
      3'd0: r = bus.alu_a & bus.alu_b;
      3'd1: r = bus.alu_a | bus.alu_b;
      3'd2: r = ~(bus.alu_a | bus.alu_b);
      3'd3: begin
        r = bus.alu_a + bus.alu_b;
        v = (bus.alu_a[15] == bus.alu_b[15]) && (r[15] != bus.alu_a[15]);
      end
      3'd4: begin
        r = bus.alu_a - bus.alu_b;
        v = (bus.alu_a[15] != bus.alu_b[15]) && (r[15] != bus.alu_a[15]);
      end
      3'd5: r = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 16'h0001 : 16'h0000;
      default: r = 16'h0000;
    endcase
    bus.alu_r    = r;
    bus.alu_ovfl = v;
    bus.alu_zero = (r == 16'h0000);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b1;
    bus.trap_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one request, waits for its accept, and returns cycles from accept edge to rsp_valid.
  task automatic send(input bit id, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op, output int lat);
    int k;
    lat = -1;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    k = 0;
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 20) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (bus.rsp_valid) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    bus.req0_valid = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset: got %b expected 0", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_op !== 3'd0) begin
      n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%0d expected 0", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    n_checks++;
    if (bus.rsp_r !== 16'h0 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got r=%h err=%b id=%b expected 0", bus.rsp_r, bus.rsp_err, bus.rsp_id);
    end
    n_checks++;
    if (bus.ovfl_trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", bus.ovfl_trap); end
  endtask

  task automatic test_add_latency();
    int lat;
    send(1'b0, 16'h7b77, 16'h0489, 3'd3, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
    n_checks++;
    if (bus.rsp_r !== 16'h8000 || bus.rsp_ovfl !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp: got r=%h ovfl=%b id=%b err=%b expected r=8000 ovfl=1 id=0 err=0",
               bus.rsp_r, bus.rsp_ovfl, bus.rsp_id, bus.rsp_err);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.alu_a !== 16'h7b77 || bus.alu_op !== 3'd3) begin
      n_fail++; $display("FAIL alu_hold: got a=%h op=%0d expected a=7b77 op=3", bus.alu_a, bus.alu_op);
    end
  endtask

  task automatic test_arbitration();
    int          ng = 0;
    int          nr = 0;
    int          both_hi = 0;
    logic        gid [4];
    logic        rid [4];
    logic [15:0] rr  [4];
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4a52; bus.req0_b = 16'hdbb7; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4a52; bus.req1_b = 16'hdbb7; bus.req1_op = 3'd1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both_hi++;
      if (bus.req0_ready && ng < 4) begin gid[ng] = 1'b0; ng++; end
      else if (bus.req1_ready && ng < 4) begin gid[ng] = 1'b1; ng++; end
      if (bus.rsp_valid && nr < 4) begin rid[nr] = bus.rsp_id; rr[nr] = bus.rsp_r; nr++; end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n_checks++;
    if (both_hi !== 0) begin n_fail++; $display("FAIL arb_one_ready: got %0d cycles with both ready expected 0", both_hi); end
    n_checks++;
    if (ng !== 3 || nr !== 3) begin
      n_fail++; $display("FAIL arb_counts: got grants=%0d rsps=%0d expected 3 3", ng, nr);
    end else begin
      n_checks++;
      if (gid[0] !== 1'b0 || gid[1] !== 1'b1 || gid[2] !== 1'b0) begin
        n_fail++; $display("FAIL arb_order: got %b%b%b expected 010", gid[0], gid[1], gid[2]);
      end
      n_checks++;
      if (rid[0] !== 1'b0 || rr[0] !== 16'h4a12 || rid[1] !== 1'b1 || rr[1] !== 16'hdbf7 ||
          rid[2] !== 1'b0 || rr[2] !== 16'h4a12) begin
        n_fail++;
        $display("FAIL arb_rsp: got %b/%h %b/%h %b/%h expected 0/4a12 1/dbf7 0/4a12",
                 rid[0], rr[0], rid[1], rr[1], rid[2], rr[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    bus.rsp_ready = 1'b0;
    send(1'b1, 16'h8000, 16'h8000, 3'd4, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d expected 2", lat); end
    n_checks++;
    if (bus.rsp_r !== 16'h0000 || bus.rsp_zero !== 1'b1 || bus.rsp_ovfl !== 1'b0 || bus.rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_rsp: got r=%h zero=%b ovfl=%b id=%b expected r=0000 zero=1 ovfl=0 id=1",
               bus.rsp_r, bus.rsp_zero, bus.rsp_ovfl, bus.rsp_id);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_op = 3'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== 16'h0000 || bus.req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b r=%h req0_ready=%b expected 1 0000 0",
                 i, bus.rsp_valid, bus.rsp_r, bus.req0_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got req0_ready=%b rsp_valid=%b expected 1 0", bus.req0_ready, bus.rsp_valid);
    end
    bus.req0_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL dropped_valid: got %0d response cycles expected 0", seen); end
  endtask

  task automatic test_illegal_op();
    int lat;
    send(1'b0, 16'h1234, 16'h5678, 3'd7, lat);
    n_checks++;
    if (lat !== 2 || bus.rsp_err !== 1'b1 || bus.rsp_r !== 16'h0000 || bus.rsp_zero !== 1'b0 || bus.rsp_ovfl !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op: got lat=%0d err=%b r=%h zero=%b ovfl=%b expected 2 1 0000 0 0",
               lat, bus.rsp_err, bus.rsp_r, bus.rsp_zero, bus.rsp_ovfl);
    end
    send(1'b0, 16'h8000, 16'h7fff, 3'd5, lat);
    n_checks++;
    if (lat !== 2 || bus.rsp_r !== 16'h0001 || bus.rsp_err !== 1'b0 || bus.rsp_ovfl !== 1'b0) begin
      n_fail++;
      $display("FAIL slt: got lat=%0d r=%h err=%b ovfl=%b expected 2 0001 0 0", lat, bus.rsp_r, bus.rsp_err, bus.rsp_ovfl);
    end
  endtask

  task automatic test_reset_in_exec();
    int lat;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_op = 3'd3;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exec_accept: got %b expected 1", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4a52; bus.req0_b = 16'hdbb7; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4a52; bus.req1_b = 16'hdbb7; bus.req1_op = 3'd1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_rsp: got %b expected 0", bus.rsp_valid); end
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_exec_grant: got r0=%b r1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (bus.rsp_valid) break;
    end
    n_checks++;
    if (lat !== 2 || bus.rsp_id !== 1'b0 || bus.rsp_r !== 16'h4a12) begin
      n_fail++; $display("FAIL rst_exec_next: got lat=%0d id=%b r=%h expected 2 0 4a12", lat, bus.rsp_id, bus.rsp_r);
    end
  endtask

  task automatic test_ovfl_trap();
    int lat;
    do_reset();
    send(1'b0, 16'h8000, 16'h8000, 3'd3, lat);
    n_checks++;
    if (lat !== 2 || bus.rsp_r !== 16'h0000 || bus.rsp_zero !== 1'b1 || bus.rsp_ovfl !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_add: got lat=%0d r=%h zero=%b ovfl=%b expected 2 0000 1 1", lat, bus.rsp_r, bus.rsp_zero, bus.rsp_ovfl);
    end
    n_checks++;
    if (bus.ovfl_trap !== TRAP_EXP) begin n_fail++; $display("FAIL trap_set: got %b expected %b", bus.ovfl_trap, TRAP_EXP); end
    send(1'b1, 16'h4a52, 16'hdbb7, 3'd0, lat);
    n_checks++;
    if (bus.rsp_r !== 16'h4a12 || bus.rsp_ovfl !== 1'b0 || bus.ovfl_trap !== TRAP_EXP) begin
      n_fail++;
      $display("FAIL trap_persist: got r=%h ovfl=%b trap=%b expected 4a12 0 %b", bus.rsp_r, bus.rsp_ovfl, bus.ovfl_trap, TRAP_EXP);
    end
    @(negedge clk);
    bus.trap_clr = 1'b1;
    @(negedge clk);
    bus.trap_clr = 1'b0;
    #1;
    n_checks++;
    if (bus.ovfl_trap !== 1'b0) begin n_fail++; $display("FAIL trap_clear: got %b expected 0", bus.ovfl_trap); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_add_latency();
    test_arbitration();
    test_backpressure();
    test_illegal_op();
    test_reset_in_exec();
    test_ovfl_trap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
